// File: rtl/lcd_text_sequencer.sv
// Feeds an HD44780-style instruction FSM: runs the display configuration, then streams buffered
// characters to a 2x16 panel, inserting DDRAM address fixes and servicing clear requests.
module lcd_text_sequencer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LINE_LEN   = 16,
    parameter int unsigned CLEAR_WAIT = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_done,
    input  logic [7:0] char_data,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic       clear_req,
    output logic [9:0] instr_data,
    output logic       instr_enable,
    input  logic       instr_done,
    output logic [4:0] cursor_pos,
    output logic       busy
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(CLEAR_WAIT + 1);

    localparam logic [PtrW:0]     FifoFull  = FIFO_DEPTH[PtrW:0];
    localparam logic [PtrW:0]     CountOne  = 1;
    localparam logic [PtrW-1:0]   PtrOne    = 1;
    localparam logic [CntW-1:0]   DelayOne  = 1;
    localparam logic [CntW-1:0]   DelayLast = CntW'(CLEAR_WAIT - 1);
    localparam logic [4:0]        Line1Last = 5'(LINE_LEN - 1);
    localparam logic [4:0]        Line2Last = 5'(2 * LINE_LEN - 1);

    localparam logic [2:0] StWaitInit = 3'd0;
    localparam logic [2:0] StIssue    = 3'd1;
    localparam logic [2:0] StWaitDone = 3'd2;
    localparam logic [2:0] StRelease  = 3'd3;
    localparam logic [2:0] StDelay    = 3'd4;
    localparam logic [2:0] StIdle     = 3'd5;

    // What the instruction in flight was, so RELEASE knows where to go next.
    localparam logic [1:0] KindCfg   = 2'd0;
    localparam logic [1:0] KindClear = 2'd1;
    localparam logic [1:0] KindChar  = 2'd2;
    localparam logic [1:0] KindAddr  = 2'd3;

    function automatic logic [7:0] cfg_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h28;
            2'd1:    return 8'h06;
            2'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    logic [2:0]      state_q, state_d;
    logic [1:0]      kind_q, kind_d;
    logic [1:0]      cfg_idx_q, cfg_idx_d;
    logic [9:0]      instr_q, instr_d;
    logic [4:0]      cursor_q, cursor_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            clr_q, clr_d;
    logic            busy_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q, count_d;
    logic            push, pop;

    assign char_ready   = (count_q != FifoFull);
    assign push         = char_valid & char_ready;
    assign instr_data   = instr_q;
    assign instr_enable = (state_q == StIssue) || (state_q == StWaitDone);
    assign cursor_pos   = cursor_q;
    assign busy         = busy_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CountOne;
        end else if (!push && pop) begin
            count_d = count_q - CountOne;
        end
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cfg_idx_d = cfg_idx_q;
        instr_d   = instr_q;
        cursor_d  = cursor_q;
        cnt_d     = cnt_q;
        clr_d     = clr_q | clear_req;
        pop       = 1'b0;
        case (state_q)
            StWaitInit: begin
                if (init_done) begin
                    cfg_idx_d = 2'd0;
                    instr_d   = {2'b00, cfg_rom(2'd0)};
                    kind_d    = KindCfg;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                state_d = instr_done ? StRelease : StWaitDone;
            end
            StWaitDone: begin
                if (instr_done) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                // Holding here until done drops tolerates a level-held FSM_done.
                if (!instr_done) begin
                    case (kind_q)
                        KindCfg, KindClear: begin
                            if (kind_q == KindCfg && cfg_idx_q != 2'd3) begin
                                cfg_idx_d = cfg_idx_q + 2'd1;
                                instr_d   = {2'b00, cfg_rom(cfg_idx_q + 2'd1)};
                                state_d   = StIssue;
                            end else begin
                                state_d  = StDelay;
                                cnt_d    = '0;
                                cursor_d = 5'd0;
                                clr_d    = clear_req;
                            end
                        end
                        KindChar: begin
                            if (cursor_q == Line1Last) begin
                                cursor_d = cursor_q + 5'd1;
                                instr_d  = 10'h0C0;
                                kind_d   = KindAddr;
                                state_d  = StIssue;
                            end else if (cursor_q == Line2Last) begin
                                cursor_d = 5'd0;
                                instr_d  = 10'h080;
                                kind_d   = KindAddr;
                                state_d  = StIssue;
                            end else begin
                                cursor_d = cursor_q + 5'd1;
                                state_d  = StIdle;
                            end
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            StDelay: begin
                if (cnt_q == DelayLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + DelayOne;
                end
            end
            StIdle: begin
                if (clr_q) begin
                    instr_d = 10'h001;
                    kind_d  = KindClear;
                    state_d = StIssue;
                end else if (count_q != '0) begin
                    pop     = 1'b1;
                    instr_d = {2'b10, mem_q[rd_ptr_q]};
                    kind_d  = KindChar;
                    state_d = StIssue;
                end
            end
            default: state_d = StWaitInit;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StWaitInit;
            kind_q    <= KindCfg;
            cfg_idx_q <= 2'd0;
            instr_q   <= 10'h000;
            cursor_q  <= 5'd0;
            cnt_q     <= '0;
            clr_q     <= 1'b0;
            busy_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cfg_idx_q <= cfg_idx_d;
            instr_q   <= instr_d;
            cursor_q  <= cursor_d;
            cnt_q     <= cnt_d;
            clr_q     <= clr_d;
            busy_q    <= (state_d != StIdle);
            count_q   <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= char_data;
        end
    end

endmodule
